targ_rx_fifo: RTL and testbench
===============================

TARG_RX_FIFO -- requirements
Module: targ_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 6, log2 of FIFO depth (64 entries).
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port rx_data  input  8  received byte from UART receiver.
REQ-005 SHALL have port rx_data_ready  input  1  one-cycle pulse; rx_data valid.
REQ-006 SHALL have port rx_data_error  input  1  one-cycle pulse; stop bit missing (framing error).
REQ-007 SHALL have port rx_endofpacket  input  1  one-cycle pulse; line gap after last byte.
REQ-008 SHALL have port clear  input  1  synchronous flush request.
REQ-009 SHALL have port rd_en  input  1  pop request.
REQ-010 SHALL have port dout  output  9  {eop_flag, byte}, registered.
REQ-011 SHALL have port empty  output  1  no entries stored.
REQ-012 SHALL have port full  output  1  count == 2^DEPTH_LOG2.
REQ-013 SHALL have port count  output  DEPTH_LOG2+1  number of stored entries.
REQ-014 SHALL have port overflow  output  1  sticky; byte dropped while full.
REQ-015 SHALL have port underflow  output  1  sticky; rd_en while empty.
REQ-016 SHALL have port err_count  output  8  framing-error counter.

Function
REQ-017 SHALL write {0, rx_data} at wr_ptr when rx_data_ready=1 and (not full or pop in same cycle).
REQ-018 SHALL drop the byte and set overflow when rx_data_ready=1, full=1 and no pop in same cycle.
REQ-019 SHALL never write a byte on rx_data_error; such cycles alter only err_count.
REQ-020 SHALL pop when rd_en=1 and empty=0; dout SHALL show the popped entry on the next cycle and hold it until the next pop.
REQ-021 SHALL ignore rd_en when empty=1, leave dout unchanged, and set underflow.
REQ-022 SHALL, on rx_endofpacket, set eop_flag of the most recently written entry if it is still stored; if count==0, the pulse SHALL be discarded.
REQ-023 SHALL, if rx_endofpacket and a write coincide, apply eop_flag to the byte written in that cycle.
REQ-024 SHALL, if rx_endofpacket coincides with a pop of that same entry (count==1), present eop_flag=1 on dout (bypass).
REQ-025 SHALL keep count unchanged on a simultaneous write and pop, including when full.
REQ-026 SHALL wrap wr_ptr and rd_ptr modulo 2^DEPTH_LOG2; count SHALL be DEPTH_LOG2+1 bits, never exceeding depth.
REQ-027 SHALL, on clear=1, zero pointers, count, overflow, underflow, err_count and dout next cycle; clear SHALL take priority over a write, pop or eop in the same cycle.
REQ-028 SHALL derive empty and full combinationally from count.

Reset
REQ-029 SHALL, on reset=1 at a clock edge, give: dout=0, count=0, empty=1, full=0, overflow=0, underflow=0, err_count=0, both pointers 0.
REQ-030 SHALL, when reset is asserted mid-operation, discard all stored entries; memory contents need not be cleared.
REQ-031 SHALL give reset priority over clear and all other inputs.

Configuration
REQ-032 SHALL implement, with TARG_RX_ERRCNT_EN defined, err_count as an 8-bit counter incremented per rx_data_error pulse, saturating at 255.
REQ-033 SHALL, without TARG_RX_ERRCNT_EN, tie err_count to 0 and instantiate no counter logic; all other behaviour SHALL be identical.

Verification
REQ-034 SHALL cover: write 0x41,0x42,0x43 then eop; pop 3 -> dout 0x041, 0x042, 0x143; empty=1 afterwards.
REQ-035 SHALL cover: 65 writes with no reads (DEPTH_LOG2=6) -> full=1, count=64, overflow=1; 64 pops return bytes 1..64 in order.
REQ-036 SHALL cover: full FIFO, write 0xAA with simultaneous rd_en -> count stays 64, overflow stays 0, 0xAA is the last byte popped.
REQ-037 SHALL cover: rd_en on empty -> underflow=1, dout unchanged; then clear -> underflow=0, count=0.
REQ-038 SHALL cover: 300 rx_data_error pulses with TARG_RX_ERRCNT_EN -> err_count=255, count=0; without the macro -> err_count=0.
REQ-039 SHALL cover: reset asserted with count=10 -> next cycle count=0, empty=1, dout=0x000.

Source files
------------

// File: rtl/targ_rx_fifo.sv
// targ_rx_fifo: receive-side byte FIFO for a UART target.
// Each entry stores {eop_flag, byte}. An end-of-packet pulse tags the most
// recently written entry so the consumer can find packet boundaries.
// Optional feature macro: TARG_RX_ERRCNT_EN enables the saturating 8-bit
// framing-error counter on err_count; without it err_count is tied to zero.
module targ_rx_fifo #(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_data_ready,
    input  logic                  rx_data_error,
    input  logic                  rx_endofpacket,
    input  logic                  clear,
    input  logic                  rd_en,
    output logic [8:0]            dout,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    output logic [7:0]            err_count
);

    localparam int AW = DEPTH_LOG2;
    localparam int CW = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = {1'b1, {AW{1'b0}}};
    localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [8:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [8:0]    dout_r;
    logic          overflow_r;
    logic          underflow_r;

    logic          empty_s;
    logic          full_s;
    logic          pop_s;
    logic          byte_in_s;
    logic          wr_s;
    logic          drop_s;
    logic          mark_s;
    logic          bypass_s;
    logic          flush_s;
    logic [AW-1:0] last_ptr_s;
    logic [CW-1:0] count_next_s;

    // Decode this cycle's write, pop, drop and end-of-packet actions.
    always_comb begin
        empty_s    = (count_r == CNT_ZERO);
        full_s     = (count_r == CNT_FULL);
        flush_s    = reset | clear;
        pop_s      = rd_en & ~empty_s;
        // A byte flagged with a framing error never reaches the queue.
        byte_in_s  = rx_data_ready & ~rx_data_error;
        wr_s       = byte_in_s & (~full_s | pop_s);
        drop_s     = byte_in_s & full_s & ~pop_s;
        // Without a coincident write, eop tags the last entry still stored.
        mark_s     = rx_endofpacket & ~wr_s & ~empty_s;
        // That last entry is leaving right now: forward the flag to dout.
        bypass_s   = mark_s & pop_s & (count_r == CNT_ONE);
        last_ptr_s = wr_ptr_r - PTR_ONE;
        case ({wr_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Storage array: byte writes and eop tagging; never reset.
    always_ff @(posedge clk) begin
        if (flush_s) begin
            // Reset and clear discard pending writes; contents are don't-care.
        end else if (wr_s) begin
            mem_r[wr_ptr_r] <= {rx_endofpacket, rx_data};
        end else if (mark_s) begin
            mem_r[last_ptr_s][8] <= 1'b1;
        end else begin
            // No storage update this cycle.
        end
    end

    // Pointers, occupancy, sticky flags and the registered read port.
    always_ff @(posedge clk) begin
        if (flush_s) begin
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            count_r     <= CNT_ZERO;
            dout_r      <= 9'h000;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            count_r     <= count_next_s;
            overflow_r  <= overflow_r | drop_s;
            underflow_r <= underflow_r | (rd_en & empty_s);
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
                dout_r   <= {mem_r[rd_ptr_r][8] | bypass_s, mem_r[rd_ptr_r][7:0]};
            end else begin
                rd_ptr_r <= rd_ptr_r;
                dout_r   <= dout_r;
            end
        end
    end

`ifdef TARG_RX_ERRCNT_EN
    logic [7:0] err_count_r;

    // Saturating count of framing-error pulses.
    always_ff @(posedge clk) begin
        if (flush_s) begin
            err_count_r <= 8'h00;
        end else if (rx_data_error && (err_count_r != 8'hFF)) begin
            err_count_r <= err_count_r + 8'h01;
        end else begin
            err_count_r <= err_count_r;
        end
    end

    assign err_count = err_count_r;
`else
    assign err_count = 8'h00;
`endif

    assign dout      = dout_r;
    assign count     = count_r;
    assign empty     = empty_s;
    assign full      = full_s;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;

endmodule

// File: tb/tb_targ_rx_fifo.sv
// Directed self-checking bench for targ_rx_fifo (default DEPTH_LOG2 = 6).
module tb_targ_rx_fifo;

    logic       clk;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_data_ready;
    logic       rx_data_error;
    logic       rx_endofpacket;
    logic       clear;
    logic       rd_en;
    logic [8:0] dout;
    logic       empty;
    logic       full;
    logic [6:0] count;
    logic       overflow;
    logic       underflow;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;

    targ_rx_fifo #(.DEPTH_LOG2(6)) dut (
        .clk            (clk),
        .reset          (reset),
        .rx_data        (rx_data),
        .rx_data_ready  (rx_data_ready),
        .rx_data_error  (rx_data_error),
        .rx_endofpacket (rx_endofpacket),
        .clear          (clear),
        .rd_en          (rd_en),
        .dout           (dout),
        .empty          (empty),
        .full           (full),
        .count          (count),
        .overflow       (overflow),
        .underflow      (underflow),
        .err_count      (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b, input logic eop);
        rx_data = b;
        rx_data_ready = 1'b1;
        rx_endofpacket = eop;
        step();
        rx_data_ready = 1'b0;
        rx_endofpacket = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++; if (dout !== 9'h000) begin errors++; $display("FAIL reset_dout got=%h exp=000", dout); end
        checks++; if (count !== 7'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags empty=%b full=%b exp 1/0", empty, full); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_sticky ovf=%b unf=%b exp 0/0", overflow, underflow); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_errcnt got=%0d exp=0", err_count); end
    endtask

    task automatic test_fill_drain();
        logic [7:0] b;
        do_clear();
        for (int i = 1; i <= 65; i++) begin
            b = i[7:0];
            push(b, 1'b0);
        end
        checks++; if (full !== 1'b1 || empty !== 1'b0) begin errors++; $display("FAIL fill_flags full=%b empty=%b exp 1/0", full, empty); end
        checks++; if (count !== 7'd64) begin errors++; $display("FAIL fill_count got=%0d exp=64", count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow got=%b exp=1", overflow); end
        for (int i = 1; i <= 64; i++) begin
            b = i[7:0];
            pop();
            checks++; if (dout !== {1'b0, b}) begin errors++; $display("FAIL drain_%0d got=%h exp=%h", i, dout, {1'b0, b}); end
        end
        checks++; if (empty !== 1'b1 || count !== 7'd0) begin errors++; $display("FAIL drain_empty empty=%b count=%0d exp 1/0", empty, count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL drain_ovf_sticky got=%b exp=1", overflow); end
    endtask

    task automatic test_full_pass();
        logic [7:0] b;
        do_clear();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clear_overflow got=%b exp=0", overflow); end
        for (int i = 1; i <= 64; i++) begin
            b = i[7:0];
            push(b, 1'b0);
        end
        rx_data = 8'hAA;
        rx_data_ready = 1'b1;
        rd_en = 1'b1;
        step();
        rx_data_ready = 1'b0;
        rd_en = 1'b0;
        checks++; if (count !== 7'd64 || full !== 1'b1) begin errors++; $display("FAIL pass_count got=%0d full=%b exp 64/1", count, full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pass_overflow got=%b exp=0", overflow); end
        checks++; if (dout !== 9'h001) begin errors++; $display("FAIL pass_dout got=%h exp=001", dout); end
        for (int j = 0; j < 64; j++) begin
            b = (j < 63) ? 8'(j + 2) : 8'hAA;
            pop();
            checks++; if (dout !== {1'b0, b}) begin errors++; $display("FAIL pass_drain_%0d got=%h exp=%h", j, dout, {1'b0, b}); end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL pass_empty got=%b exp=1", empty); end
    endtask

    task automatic test_eop();
        do_clear();
        push(8'h41, 1'b0);
        push(8'h42, 1'b0);
        push(8'h43, 1'b0);
        rx_endofpacket = 1'b1;
        step();
        rx_endofpacket = 1'b0;
        pop();
        checks++; if (dout !== 9'h041) begin errors++; $display("FAIL eop_pop0 got=%h exp=041", dout); end
        pop();
        checks++; if (dout !== 9'h042) begin errors++; $display("FAIL eop_pop1 got=%h exp=042", dout); end
        pop();
        checks++; if (dout !== 9'h143) begin errors++; $display("FAIL eop_pop2 got=%h exp=143", dout); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL eop_empty got=%b exp=1", empty); end
        // eop on an empty FIFO is discarded
        rx_endofpacket = 1'b1;
        step();
        rx_endofpacket = 1'b0;
        push(8'h20, 1'b0);
        pop();
        checks++; if (dout !== 9'h020) begin errors++; $display("FAIL eop_discard got=%h exp=020", dout); end
        // eop coincident with a write tags that byte
        push(8'h30, 1'b1);
        pop();
        checks++; if (dout !== 9'h130) begin errors++; $display("FAIL eop_with_write got=%h exp=130", dout); end
        // eop coincident with popping the only entry
        push(8'h10, 1'b0);
        rx_endofpacket = 1'b1;
        rd_en = 1'b1;
        step();
        rx_endofpacket = 1'b0;
        rd_en = 1'b0;
        checks++; if (dout !== 9'h110) begin errors++; $display("FAIL eop_bypass got=%h exp=110", dout); end
        checks++; if (count !== 7'd0) begin errors++; $display("FAIL eop_bypass_count got=%0d exp=0", count); end
    endtask

    task automatic test_underflow();
        pop();
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_set got=%b exp=1", underflow); end
        checks++; if (dout !== 9'h110) begin errors++; $display("FAIL underflow_dout got=%h exp=110", dout); end
        checks++; if (count !== 7'd0) begin errors++; $display("FAIL underflow_count got=%0d exp=0", count); end
        do_clear();
        checks++; if (underflow !== 1'b0 || count !== 7'd0) begin errors++; $display("FAIL underflow_clear unf=%b count=%0d exp 0/0", underflow, count); end
        checks++; if (dout !== 9'h000) begin errors++; $display("FAIL clear_dout got=%h exp=000", dout); end
    endtask

    task automatic test_err();
        logic [7:0] exp_err;
`ifdef TARG_RX_ERRCNT_EN
        exp_err = 8'd255;
`else
        exp_err = 8'd0;
`endif
        for (int i = 0; i < 300; i++) begin
            rx_data_error = 1'b1;
            rx_data = 8'h55;
            rx_data_ready = (i == 7) ? 1'b1 : 1'b0;
            step();
            rx_data_error = 1'b0;
            rx_data_ready = 1'b0;
            step();
        end
        checks++; if (err_count !== exp_err) begin errors++; $display("FAIL err_count got=%0d exp=%0d", err_count, exp_err); end
        checks++; if (count !== 7'd0 || empty !== 1'b1) begin errors++; $display("FAIL err_no_write count=%0d exp=0", count); end
        do_clear();
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL err_clear got=%0d exp=0", err_count); end
    endtask

    task automatic test_clear_priority();
        for (int i = 0; i < 5; i++) push(8'(8'h60 + i), 1'b0);
        clear = 1'b1;
        rx_data = 8'h77;
        rx_data_ready = 1'b1;
        rd_en = 1'b1;
        rx_endofpacket = 1'b1;
        step();
        clear = 1'b0;
        rx_data_ready = 1'b0;
        rd_en = 1'b0;
        rx_endofpacket = 1'b0;
        checks++; if (count !== 7'd0 || empty !== 1'b1) begin errors++; $display("FAIL clear_prio_count got=%0d exp=0", count); end
        checks++; if (dout !== 9'h000) begin errors++; $display("FAIL clear_prio_dout got=%h exp=000", dout); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 11; i++) push(8'(8'h80 + i), 1'b0);
        pop();
        checks++; if (count !== 7'd10 || dout !== 9'h080) begin errors++; $display("FAIL mid_pre count=%0d dout=%h exp 10/080", count, dout); end
        reset = 1'b1;
        clear = 1'b1;
        step();
        reset = 1'b0;
        clear = 1'b0;
        checks++; if (count !== 7'd0 || empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL mid_reset count=%0d empty=%b exp 0/1", count, empty); end
        checks++; if (dout !== 9'h000) begin errors++; $display("FAIL mid_reset_dout got=%h exp=000", dout); end
        push(8'h99, 1'b0);
        pop();
        checks++; if (dout !== 9'h099) begin errors++; $display("FAIL mid_after got=%h exp=099", dout); end
    endtask

    initial begin
        reset = 1'b1;
        rx_data = 8'h00;
        rx_data_ready = 1'b0;
        rx_data_error = 1'b0;
        rx_endofpacket = 1'b0;
        clear = 1'b0;
        rd_en = 1'b0;
        test_reset();
        test_fill_drain();
        test_full_pass();
        test_eop();
        test_underflow();
        test_err();
        test_clear_priority();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
